// File: rtl/sub_bytes_seq_pkg.sv
// Shared definitions for the time-multiplexed SubBytes engine.
// Latency: n/a (constants, types and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: forward/inverse S-box byte tables, FSM state enum, beat-count helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  // Number of beats needed to push a block through the physical lanes.
  function automatic int beats(input int data_bytes, input int lanes);
    return data_bytes / lanes;
  endfunction

  // Beat counter width; a single-beat engine still keeps a 1-bit counter.
  function automatic int beat_width(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Block handshake bundle between a producer/consumer and the SubBytes engine.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the input and the output side.
// master: drives enc_or_dec_i, in_valid_i, data_i, out_ready_i; sees in_ready_o, out_valid_o, data_o.
// slave : the engine side of the same signals.
interface sub_bytes_seq_if #(
  parameter int DATA_BYTES = 16
) ();
  logic                    enc_or_dec_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [8*DATA_BYTES-1:0] data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [8*DATA_BYTES-1:0] data_o;

  modport master (
    output enc_or_dec_i, in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o
  );

  modport slave (
    input  enc_or_dec_i, in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o
  );
endinterface

// File: rtl/sub_bytes_seq_lane.sv
// One S-box byte lane: forward or inverse substitution of a single byte.
// Latency: combinational.
// Backpressure: none; the enclosing engine sequences the lane.
// Ports: din (byte in), enc (1 = forward, 0 = inverse), dout (substituted byte).
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       enc,
  output logic [7:0] dout
);
  assign dout = enc ? SBOX_FWD[din] : SBOX_INV[din];
endmodule

// File: rtl/sub_bytes_seq.sv
// Time-multiplexed SubBytes/InvSubBytes over LANES lanes, DATA_BYTES/LANES beats.
// Latency: BEATS cycles from input accept to out_valid_o; one block per BEATS+1 cycles.
// Backpressure: DONE holds block until out_ready_i; in_ready_o follows out_ready_i there.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of sub_bytes_seq_if).
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int DATA_BYTES = 16,
  parameter int LANES      = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sub_bytes_seq_if.slave  bus
);
  localparam int BEATS  = beats(DATA_BYTES, LANES);
  localparam int BEAT_W = beat_width(BEATS);

  state_t                      state_q, state_d;
  logic [DATA_BYTES-1:0][7:0]  blk_q, blk_d;
  logic                        mode_q, mode_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [LANES-1:0][7:0]       lane_in, lane_out;
  logic                        in_ready;
  logic                        accept;
  logic                        last_beat;

  // The only combinational in->out path: a DONE engine frees itself the
  // same cycle its result is taken, enabling back-to-back accepts.
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready_i);
  assign accept    = bus.in_valid_i & in_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.data_o      = blk_q;

  // Lane l works on byte beat*LANES + l of the block register.
  always_comb begin
    lane_in = blk_q[LANES-1:0];
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        for (int l = 0; l < LANES; l++) begin
          lane_in[l] = blk_q[b*LANES + l];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .din  (lane_in[l]),
      .enc  (mode_q),
      .dout (lane_out[l])
    );
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    mode_d  = mode_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // In-place write-back of the lanes into the current beat's bytes.
        for (int b = 0; b < BEATS; b++) begin
          if (beat_q == BEAT_W'(b)) begin
            for (int l = 0; l < LANES; l++) begin
              blk_d[b*LANES + l] = lane_out[l];
            end
          end
        end
        if (last_beat) begin
          state_d = ST_DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) state_d = bus.in_valid_i ? ST_BUSY : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // accept only occurs in IDLE or DONE, so it never collides with write-back.
    if (accept) begin
      blk_d  = bus.data_i;
      mode_d = bus.enc_or_dec_i;
      beat_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      mode_q  <= 1'b1;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      mode_q  <= mode_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq: LANES 1/2/4/16 at 16 bytes, plus 4 bytes/4 lanes.
// Expected blocks come from an S-box model built from GF(2^8) arithmetic.
// Instances: 0:L=1 1:L=2 2:L=4 3:L=16 (DATA_BYTES=16), 4:L=4 (DATA_BYTES=4).
module tb_sub_bytes_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int N_INST = 5;

  logic         sw_valid  [N_INST];
  logic         sw_enc    [N_INST];
  logic         sw_oready [N_INST];
  logic [127:0] sw_din    [N_INST];
  logic         sw_irdy   [N_INST];
  logic         sw_ovld   [N_INST];
  logic [127:0] sw_dout   [N_INST];

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    localparam int DB = (g == 4) ? 4 : 16;
    localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 3) ? 16 : 4;
    sub_bytes_seq_if #(.DATA_BYTES(DB)) bus ();
    assign bus.enc_or_dec_i = sw_enc[g];
    assign bus.in_valid_i   = sw_valid[g];
    assign bus.data_i       = sw_din[g][8*DB-1:0];
    assign bus.out_ready_i  = sw_oready[g];
    assign sw_irdy[g]       = bus.in_ready_o;
    assign sw_ovld[g]       = bus.out_valid_o;
    assign sw_dout[g]       = 128'(bus.data_o);
    sub_bytes_seq #(.DATA_BYTES(DB), .LANES(LN)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_q [$];
  int           acc_q [$];

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  typedef struct {
    string        name;
    int           k;
    bit           enc;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [7];

  function automatic int beats_of(input int k);
    case (k)
      0:       return 16;
      1:       return 8;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input bit enc, input int db);
    logic [127:0] r = '0;
    for (int i = 0; i < db; i++) r[8*i +: 8] = enc ? fwd_tab[d[8*i +: 8]] : inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for out_valid_o", name);
  endtask

  // Waits (bounded) for out_valid_o, then checks latency and data against
  // the scoreboard front and completes the output handshake.
  task automatic finish_block(input int k, input string name);
    bit ok = 0;
    for (int g = 0; g < 64 && !ok; g++) begin
      @(negedge clk);
      ok = sw_ovld[k];
    end
    if (!ok || exp_q.size() == 0) begin
      fail_now(name);
      exp_q.delete();
      acc_q.delete();
    end else begin
      check({name, "_latency"}, 128'(cyc - acc_q.pop_front()), 128'(beats_of(k)));
      check({name, "_data"}, sw_dout[k], exp_q.pop_front());
    end
    @(posedge clk); #1;
    sw_oready[k] = 1'b1;
    @(posedge clk); #1;
    sw_oready[k] = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    @(posedge clk); #1;
    sw_valid[v.k]  = 1'b1;
    sw_enc[v.k]    = v.enc;
    sw_din[v.k]    = v.din;
    sw_oready[v.k] = 1'b0;
    @(negedge clk);
    check({v.name, "_in_ready"}, 128'(sw_irdy[v.k]), 128'(1));
    exp_q.push_back(v.dout);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    sw_valid[v.k] = 1'b0;
    sw_enc[v.k]   = ~v.enc;
    sw_din[v.k]   = {$urandom, $urandom, $urandom, $urandom};
    finish_block(v.k, v.name);
  endtask

  task automatic run_sweep(input int k, input int nblk);
    int           sent = 0;
    int           got = 0;
    int           guard = 0;
    bit           prev_ovld = 0;
    bit           ivld = 0;
    bit           ien = 1;
    logic [127:0] idat = '0;
    int           db = (k == 4) ? 4 : 16;
    while (got < nblk && guard < 4000) begin
      guard++;
      @(posedge clk); #1;
      if (!ivld && sent < nblk && $urandom_range(3) != 0) begin
        ivld = 1'b1;
        idat = {$urandom, $urandom, $urandom, $urandom};
        if (db == 4) idat[127:32] = '0;
        ien  = 1'($urandom_range(1));
      end
      sw_valid[k]  = ivld;
      sw_din[k]    = ivld ? idat : {$urandom, $urandom, $urandom, $urandom};
      sw_enc[k]    = ivld ? ien : 1'($urandom_range(1));
      sw_oready[k] = ($urandom_range(2) != 0);
      @(negedge clk);
      if (sw_ovld[k]) check("sweep_hs_ready_follows_out_ready", 128'(sw_irdy[k]), 128'(sw_oready[k]));
      if (!sw_ovld[k] && acc_q.size() > 0) check("sweep_busy_not_ready", 128'(sw_irdy[k]), 128'(0));
      if (sw_ovld[k] && !prev_ovld && acc_q.size() > 0)
        check("sweep_latency", 128'(cyc - acc_q[0]), 128'(beats_of(k)));
      if (ivld && sw_irdy[k]) begin
        exp_q.push_back(model(idat, ien, db));
        acc_q.push_back(cyc + 1);
        ivld = 1'b0;
        sent++;
      end
      if (sw_ovld[k] && sw_oready[k]) begin
        if (exp_q.size() == 0) begin
          check("sweep_unexpected_output", 128'(1), 128'(0));
        end else begin
          check("sweep_data", sw_dout[k], exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        got++;
      end
      prev_ovld = sw_ovld[k];
    end
    if (got < nblk) fail_now("sweep");
    check("sweep_scoreboard_empty", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    sw_valid[k]  = 1'b0;
    sw_oready[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] xin;
    logic [127:0] xs;
    bit           seen;
    bit           ok;

    for (int k = 0; k < N_INST; k++) begin
      sw_valid[k]  = 1'b0;
      sw_enc[k]    = 1'b1;
      sw_oready[k] = 1'b0;
      sw_din[k]    = '0;
    end
    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    vecs[0] = '{name: "fips_fwd_l4",  k: 2, enc: 1'b1, din: 128'h00112233445566778899aabbccddeeff, dout: 128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[1] = '{name: "fips_inv_l4",  k: 2, enc: 1'b0, din: 128'h638293c31bfc33f5c4eeacea4bc12816, dout: 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{name: "word_fwd",     k: 4, enc: 1'b1, din: 128'h00010203, dout: 128'h637c777b};
    vecs[3] = '{name: "word_inv",     k: 4, enc: 1'b0, din: 128'h63000000, dout: 128'h00525252};
    vecs[4] = '{name: "fips_fwd_l1",  k: 0, enc: 1'b1, din: 128'h00112233445566778899aabbccddeeff, dout: 128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[5] = '{name: "fips_inv_l16", k: 3, enc: 1'b0, din: 128'h638293c31bfc33f5c4eeacea4bc12816, dout: 128'h00112233445566778899aabbccddeeff};
    vecs[6] = '{name: "zero_fwd_l2",  k: 1, enc: 1'b1, din: 128'h0, dout: 128'h63636363636363636363636363636363};

    // Reset state on every instance.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N_INST; k++) begin
      check("reset_out_valid", 128'(sw_ovld[k]), 128'(0));
      check("reset_in_ready", 128'(sw_irdy[k]), 128'(1));
      check("reset_data", sw_dout[k], 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    // Backpressure: hold DONE for 10 cycles while the input side churns.
    xin = {$urandom, $urandom, $urandom, $urandom};
    xs  = model(xin, 1'b1, 16);
    @(posedge clk); #1;
    sw_valid[2] = 1'b1; sw_enc[2] = 1'b1; sw_din[2] = xin; sw_oready[2] = 1'b0;
    @(negedge clk);
    check("bp_accept_in_ready", 128'(sw_irdy[2]), 128'(1));
    exp_q.push_back(xs);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    sw_valid[2] = 1'b0;
    ok = 1'b0;
    for (int g = 0; g < 32 && !ok; g++) begin
      @(negedge clk);
      ok = sw_ovld[2];
    end
    if (!ok) fail_now("bp_wait_done");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sw_enc[2]   = i[0];
      sw_din[2]   = {$urandom, $urandom, $urandom, $urandom};
      sw_valid[2] = 1'($urandom_range(1));
      @(negedge clk);
      check("bp_hold_out_valid", 128'(sw_ovld[2]), 128'(1));
      check("bp_hold_in_ready", 128'(sw_irdy[2]), 128'(0));
      check("bp_hold_data", sw_dout[2], xs);
    end
    // Release and present the next block in the same cycle.
    @(posedge clk); #1;
    sw_oready[2] = 1'b1; sw_valid[2] = 1'b1; sw_enc[2] = 1'b0; sw_din[2] = xs;
    @(negedge clk);
    check("b2b_in_ready", 128'(sw_irdy[2]), 128'(1));
    check("b2b_out_data", sw_dout[2], exp_q.pop_front());
    void'(acc_q.pop_front());
    exp_q.push_back(xin);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    sw_valid[2] = 1'b0; sw_oready[2] = 1'b0;
    @(negedge clk);
    check("b2b_busy_out_valid", 128'(sw_ovld[2]), 128'(0));
    finish_block(2, "b2b_second");

    // Reset while the block register is on beat 2.
    @(posedge clk); #1;
    sw_valid[2] = 1'b1; sw_enc[2] = 1'b1; sw_din[2] = {$urandom, $urandom, $urandom, $urandom};
    sw_oready[2] = 1'b1;
    @(negedge clk);
    check("abort_accept_in_ready", 128'(sw_irdy[2]), 128'(1));
    @(posedge clk); #1;
    sw_valid[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 128'(sw_ovld[2]), 128'(0));
    check("abort_in_ready", 128'(sw_irdy[2]), 128'(1));
    check("abort_data", sw_dout[2], 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sw_ovld[2]) seen = 1'b1;
    end
    check("abort_no_output", 128'(seen), 128'(0));
    sw_oready[2] = 1'b0;
    apply_vec(vecs[0]);

    // Randomised sweep on every lane configuration.
    for (int k = 0; k < N_INST; k++) run_sweep(k, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Parametrised, time-multiplexed AES SubBytes/InvSubBytes engine. It substitutes a DATA_BYTES-wide block through LANES physical S-box lanes over DATA_BYTES/LANES beats, with valid/ready handshakes on both sides. It replaces the combinational word substitution in the key schedule (DATA_BYTES=4) and the round datapath (DATA_BYTES=16). Setting LANES below DATA_BYTES trades throughput for S-box area.

## Interface
- DATA_BYTES, 16, block width in bytes; legal values 4 or 16.
- LANES, 4, S-box lanes instantiated; must divide DATA_BYTES; 1 ≤ LANES ≤ DATA_BYTES.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- enc_or_dec_i  in  1  1 = forward S-box, 0 = inverse S-box; sampled with the input handshake.
- in_valid_i  in  1  input block valid.
- in_ready_o  out  1  engine can accept a block.
- data_i  in  8*DATA_BYTES  input block; byte n = data_i[8n+7:8n].
- out_valid_o  out  1  substituted block available.
- out_ready_i  in  1  consumer accepts the block.
- data_o  out  8*DATA_BYTES  substituted block; byte n maps to byte n of the input.

## Operation
- BEATS = DATA_BYTES/LANES. A single block register holds the data and is substituted in place. A mode flop and a beat counter (width clog2(BEATS), minimum 1 bit) complete the state.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on in_valid_i & in_ready_o: capture data_i and enc_or_dec_i; set beat = 0.
  - BUSY: each cycle, lane l replaces byte beat*LANES + l with S(byte) or S⁻¹(byte) according to the latched mode. Then beat++.
  - BUSY → DONE on the cycle that writes beat BEATS-1.
  - DONE: out_valid_o = 1 and data_o = block register.
    - On out_ready_i & !in_valid_i: → IDLE.
    - On out_ready_i & in_valid_i: capture the new block and go → BUSY (back-to-back).
- in_ready_o = (state == IDLE) | (state == DONE & out_ready_i). It is combinational on out_ready_i, and is the only combinational in→out path.
- The mode is latched per block. Changes to enc_or_dec_i while the engine is in BUSY or DONE have no effect.
- data_i is ignored except on the accept cycle. data_o is stable throughout DONE until the handshake completes.
- In IDLE and BUSY, data_o shows the block register contents, which may be partially substituted. Consumers qualify data_o with out_valid_o.
- Reset at any time, including mid-BUSY or in DONE, discards the block: state → IDLE, beat → 0. No output is produced for the discarded block.

## Timing
- Reset values: state IDLE, out_valid_o 0, in_ready_o 1, data_o all-zero, beat 0, mode 1.
- Latency: a block accepted at edge k has out_valid_o asserted from edge k+BEATS (BEATS=4 gives 4 cycles; LANES=DATA_BYTES gives 1 cycle).
- Throughput: one block per BEATS+1 cycles with out_ready_i held high, including back-to-back accepts from DONE.
- Backpressure: out_valid_o stays high and data_o holds for any number of cycles with out_ready_i low. in_ready_o stays low during that time.

## Structure
- Package aes_pkg holds:
  - the 256-entry forward and inverse S-box constant arrays, as byte arrays indexed by input byte;
  - the FSM state enum;
  - the BEATS derivation.
- Sub-module sbox_lane contains one byte lane: an 8-bit input, a mode input, and an 8-bit output muxed between the forward and inverse table lookups. It is instantiated LANES times with a generate loop.
- The top level contains the FSM, beat counter, block register, and a per-beat byte select/write-back. Lane byte select is a mux indexed by beat.

## Test plan
- DATA_BYTES=16, LANES=4, mode 1, data_i=0x00112233445566778899aabbccddeeff → data_o=0x638293c31bfc33f5c4eeacea4bc12816, out_valid_o first high 4 cycles after accept.
- Same configuration, mode 0, data_i=0x638293c31bfc33f5c4eeacea4bc12816 → data_o=0x00112233445566778899aabbccddeeff (round trip).
- DATA_BYTES=4, LANES=4, mode 1, data_i=0x00010203 → data_o=0x637c777b after 1 cycle. With mode 0 and data_i=0x63000000 → data_o=0x00525252.
- Hold out_ready_i low for 10 cycles in DONE while toggling enc_or_dec_i and data_i → data_o unchanged, in_ready_o low. Then assert out_ready_i and in_valid_i together → the next block is accepted in the same cycle.
- Assert rst_i during beat 2 of a block → next cycle out_valid_o=0, in_ready_o=1, data_o=0. No output appears for the aborted block. The next block completes normally.
- Sweep LANES ∈ {1, 2, 4, 16} with random blocks and modes against a table-based reference model. Check latency = BEATS and that the input and output handshakes never overlap except in DONE with out_ready_i high.
